// File: rtl/pipe_skid_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_skid_reg
// Purpose  : Pipeline stage register with valid/ready handshake and a
//            two-entry skid buffer. The upstream ready depends only on
//            registered state and flush, so there is no combinational path
//            from out_ready back to in_ready. A flush empties the stage and
//            parks a bubble (NOP) value on out_data. A saturating counter
//            tracks the cycles in which downstream stalls a valid beat.
// Ports    : clk, reset     - clock and synchronous active-high reset
//            flush          - drop all held entries this cycle
//            in_valid/in_ready/in_data    - upstream handshake and payload
//            out_valid/out_ready/out_data - downstream handshake and payload
//            occupancy      - held entries (0, 1 or 2)
//            stall_cnt      - saturating count of out_valid & !out_ready cycles
// Revision : 1.0 - initial release
// ============================================================================
module pipe_skid_reg #(
    parameter int               WIDTH  = 32,
    parameter logic [WIDTH-1:0] BUBBLE = WIDTH'(32'h0000_0013),
    parameter int               CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_main;
    logic [WIDTH-1:0]   w_main_next;
    logic [WIDTH-1:0]   r_skid;
    logic [WIDTH-1:0]   w_skid_next;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic               w_accept;
    logic               w_send;

    // flush is the only input allowed to reach in_ready combinationally.
    assign in_ready  = (r_state != FULL) && !flush;
    assign out_valid = (r_state != EMPTY);
    assign out_data  = r_main;
    assign occupancy = r_state;
    assign stall_cnt = r_stall_cnt;

    assign w_accept  = in_valid && in_ready;
    assign w_send    = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= EMPTY;
            r_main  <= BUBBLE;
            r_skid  <= BUBBLE;
        end else begin
            r_state <= w_state_next;
            r_main  <= w_main_next;
            r_skid  <= w_skid_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_main_next  = r_main;
        w_skid_next  = r_skid;
        if (flush) begin
            // Skid contents are irrelevant once the stage is empty; hold them.
            w_state_next = EMPTY;
            w_main_next  = BUBBLE;
        end else begin
            unique case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_state_next = ONE;
                        w_main_next  = in_data;
                    end
                end
                ONE: begin
                    if (w_accept && w_send) begin
                        w_main_next  = in_data;
                    end else if (w_accept) begin
                        w_state_next = FULL;
                        w_skid_next  = in_data;
                    end else if (w_send) begin
                        w_state_next = EMPTY;
                        w_main_next  = BUBBLE;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a send can move the state.
                    if (w_send) begin
                        w_state_next = ONE;
                        w_main_next  = r_skid;
                    end
                end
                default: begin
                    w_state_next = EMPTY;
                    w_main_next  = BUBBLE;
                end
            endcase
        end
    end

    // Counts the flush cycle too; flush never clears the counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (out_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_skid_reg
// Purpose  : Self-checking bench for pipe_skid_reg: directed scenarios plus
//            randomized traffic, all checked against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_skid_reg;

    localparam int          W   = 32;
    localparam int          CW  = 4;
    localparam logic [31:0] BUB = 32'h0000_0013;
    localparam int          SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [1:0]    occupancy;
    logic [CW-1:0] stall_cnt;

    pipe_skid_reg #(
        .WIDTH  (W),
        .BUBBLE (BUB),
        .CNT_W  (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] q[$];      // beats held by the stage, oldest first
    int          mcnt = 0;  // model stall counter

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, then
    // advance the model across the rising edge.
    task automatic step(input logic rst_i, input logic fl, input logic iv,
                        input logic [31:0] d, input logic ordy);
        int  sz;
        logic ev, er, acc;
        @(negedge clk);
        reset = rst_i; flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
        #1;
        sz  = q.size();
        ev  = (sz != 0);
        er  = (sz < 2) && !fl;
        acc = iv && er;
        if (!rst_i) begin
            chk("out_valid", 32'(out_valid), 32'(ev));
            chk("out_data",  out_data, ev ? q[0] : BUB);
            chk("occupancy", 32'(occupancy), 32'(sz));
            chk("stall_cnt", 32'(stall_cnt), 32'(mcnt));
            chk("in_ready",  32'(in_ready), 32'(er));
            out_ready = !ordy;
            #1;
            chk("in_ready_indep", 32'(in_ready), 32'(er));
            out_ready = ordy;
            #1;
        end
        @(posedge clk);
        if (rst_i) begin
            q.delete();
            mcnt = 0;
        end else begin
            if (ev && !ordy && mcnt < SAT) mcnt++;
            if (fl) begin
                q.delete();
            end else begin
                if (ev && ordy) void'(q.pop_front());
                if (acc) q.push_back(d);
            end
        end
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // Reset, then idle.
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        #1;
        chk("rst_out_data", out_data, 32'h13);
        chk("rst_stall",    32'(stall_cnt), 32'd0);

        // Streaming with downstream always ready.
        step(0, 0, 1, 32'h1, 1);
        step(0, 0, 1, 32'h2, 1);
        step(0, 0, 1, 32'h3, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);

        // Skid: A, B absorbed while stalled, C held off upstream.
        step(0, 0, 1, 32'hA, 0);
        step(0, 0, 1, 32'hB, 0);
        step(0, 0, 1, 32'hC, 0);
        step(0, 0, 1, 32'hC, 0);
        step(0, 0, 1, 32'hC, 1);
        step(0, 0, 1, 32'hC, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);

        // Flush while FULL with a beat offered in the flush cycle.
        step(0, 0, 1, 32'hA, 0);
        step(0, 0, 1, 32'hB, 0);
        step(0, 1, 1, 32'hD, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);

        // Counter saturation, survives flush, cleared by reset.
        step(0, 0, 1, 32'h55, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0);
        #1;
        chk("sat_stall", 32'(stall_cnt), SAT);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        #1;
        chk("sat_after_flush", 32'(stall_cnt), SAT);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        #1;
        chk("stall_after_reset", 32'(stall_cnt), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 10000; i++) begin
            step(($urandom_range(0, 999) == 0),
                 ($urandom_range(0, 31) == 0),
                 ($urandom_range(0, 3) != 0),
                 $urandom,
                 ($urandom_range(0, 2) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
